br32_ctrl: RTL and testbench
============================

# br32_ctrl

Challenge-response controller for the 32-bit bistable ring PUF macro (`BR32`). It accepts a 32-bit challenge from the host over a valid/ready handshake and drives it onto the ring. For each evaluation it pulses the ring reset, waits for the ring to settle, then samples the synchronized ring output. It repeats this NUM_EVALS times and returns a majority-voted response bit plus a ones count (stability metric) over a second valid/ready handshake. It sits between the host/scan interface and the hard PUF macro; it is the driving end of the macro's RESET/C/OUT interface.

## Interface
- RESET_CYCLES, 4: cycles PUF_RESET is held high per evaluation (≥1)
- SETTLE_CYCLES, 64: cycles ring runs free before sampling (must exceed SYNC_STAGES)
- NUM_EVALS, 7: evaluations per challenge; odd, ≥1; elaboration error otherwise
- SYNC_STAGES, 2: flops in PUF_OUT synchronizer (≥2)

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- CHAL  in  32  challenge from host
- CHAL_VALID  in  1  challenge valid
- CHAL_READY  out  1  controller can accept a challenge
- PUF_C  out  32  challenge to ring (drives BR32 C)
- PUF_RESET  out  1  ring reset (drives BR32 RESET)
- PUF_OUT  in  1  ring output (BR32 OUT); asynchronous to CLK
- RESP  out  1  majority response
- RESP_ONES  out  $clog2(NUM_EVALS+1)  count of evaluations that sampled 1
- RESP_VALID  out  1  response valid
- RESP_READY  in  1  host accepts response
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ARM, SETTLE, SAMPLE, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - CHAL_READY=1.
  - On CHAL_VALID&&CHAL_READY: latch CHAL into PUF_C, clear the ones and evaluation counters, go to ARM.
  - CHAL_VALID while CHAL_READY=0 is ignored.
- ARM: PUF_RESET=1 for RESET_CYCLES cycles, then go to SETTLE.
- SETTLE: PUF_RESET=0 for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - PUF_RESET=0.
  - Add the synchronizer output to the ones counter and increment the evaluation counter.
  - If evaluations < NUM_EVALS, go to ARM; else go to DONE.
- DONE:
  - RESP_VALID=1, RESP=(ones > NUM_EVALS/2), RESP_ONES=ones.
  - RESP, RESP_ONES and RESP_VALID are held stable until RESP_READY=1.
  - On RESP_READY: go to IDLE.
- PUF_RESET=1 in IDLE and DONE; the ring stays parked in reset.
- PUF_C holds the last challenge until the next accept.
- Counters are saturation-free by construction: the ones count never exceeds NUM_EVALS.
- Reset values (also forced asynchronously on RESET mid-operation): state=IDLE, PUF_RESET=1, PUF_C=0, CHAL_READY=0, RESP_VALID=0, RESP=0, RESP_ONES=0, BUSY=0, synchronizer flops=0.
- CHAL_READY is a registered flag:
  - 0 during reset; rises on the first CLK edge after RESET deasserts.
  - Cleared on accept; set again on the edge leaving DONE.
- A partial result interrupted by reset is discarded; nothing is emitted.

## Timing
- Accept on edge t:
  - PUF_C valid and PUF_RESET=1 during cycles t+1..t+RESET_CYCLES.
  - SETTLE occupies the next SETTLE_CYCLES cycles; SAMPLE occupies the following cycle.
- Per-evaluation length E = RESET_CYCLES+SETTLE_CYCLES+1.
- RESP_VALID rises in the cycle after edge t+NUM_EVALS·E, so latency is NUM_EVALS·E+1 cycles. With defaults this is 7·69+1 = 484.
- If RESP_READY=1 in the first RESP_VALID cycle, the response is consumed on that edge, and CHAL_READY=1 the following cycle.
- Back-to-back throughput: one challenge per NUM_EVALS·E+2 cycles.
- The value sampled in SAMPLE is PUF_OUT as seen through SYNC_STAGES flops. SETTLE_CYCLES > SYNC_STAGES guarantees no stale pre-reset value is sampled.

## Structure
- Package br32_pkg:
  - BR32_WIDTH=32
  - FSM state enum
  - function computing the RESP_ONES width
- Sub-module br32_sync: SYNC_STAGES-deep single-bit synchronizer, asynchronous active-high reset to 0; instantiated once on PUF_OUT.
- The bench uses a behavioural BR32 model:
  - OUT is forced 0 while RESET=1.
  - After RESET falls, OUT follows a scripted per-evaluation value.

## Test plan
Bench parameters: RESET_CYCLES=2, SETTLE_CYCLES=4, NUM_EVALS=3, SYNC_STAGES=2 (E=7, latency 22).
- Reset check: assert RESET mid-cycle, no clock -> PUF_RESET=1, PUF_C=0, CHAL_READY=0, RESP_VALID=0 immediately; CHAL_READY=1 one edge after release.
- Stable 1: CHAL=0xDEADBEEF, model returns 1,1,1 -> PUF_C=0xDEADBEEF; PUF_RESET high 2 cycles / low 5 cycles ×3; RESP_VALID 22 cycles after accept; RESP=1, RESP_ONES=3.
- Noisy: CHAL=0x00000001, model returns 1,0,0 -> RESP=0, RESP_ONES=1; second run with 0,1,1 -> RESP=1, RESP_ONES=2.
- Backpressure: hold RESP_READY=0 for 10 cycles in DONE while CHAL_VALID=1 with CHAL=0x12345678 -> RESP/RESP_ONES stable, CHAL_READY=0, challenge not accepted; after RESP_READY=1, CHAL_READY=1 next cycle and 0x12345678 is accepted.
- Reset mid-operation: assert RESET during SETTLE of evaluation 2 -> all outputs return to reset values; the next challenge yields a RESP_ONES from exactly 3 fresh evaluations.
- Back-to-back: CHAL_VALID and RESP_READY tied high -> successive accepts exactly 23 cycles apart; BUSY low for exactly one cycle between them.

Source files
------------

// File: rtl/br32_pkg.sv
// Shared types and constants for the BR32 bistable-ring PUF controller.
package br32_pkg;

    localparam int BR32_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Width needed to hold a ones count from 0 up to num_evals inclusive.
    function automatic int ones_width(input int num_evals);
        return (num_evals < 1) ? 1 : $clog2(num_evals + 1);
    endfunction

endpackage

// File: rtl/br32_if.sv
// Host handshakes plus the ring macro pins, bundled for the controller.
// Both handshakes use strict valid/ready: a transfer happens on a rising
// CLK edge where valid and ready are both high; valid and its payload must
// hold steady until that edge, and ready may not depend on valid.
interface br32_if #(
    parameter int NUM_EVALS = 7
);
    import br32_pkg::*;

    localparam int ONES_W = ones_width(NUM_EVALS);

    logic [BR32_WIDTH-1:0] CHAL;
    logic                  CHAL_VALID;
    logic                  CHAL_READY;
    logic [BR32_WIDTH-1:0] PUF_C;
    logic                  PUF_RESET;
    logic                  PUF_OUT;
    logic                  RESP;
    logic [ONES_W-1:0]     RESP_ONES;
    logic                  RESP_VALID;
    logic                  RESP_READY;
    logic                  BUSY;
    state_t                dbg_state;

    // Controller side.
    modport slave (
        input  CHAL, CHAL_VALID, RESP_READY, PUF_OUT,
        output CHAL_READY, PUF_C, PUF_RESET, RESP, RESP_ONES, RESP_VALID,
               BUSY, dbg_state
    );

    // Host / ring side.
    modport master (
        output CHAL, CHAL_VALID, RESP_READY, PUF_OUT,
        input  CHAL_READY, PUF_C, PUF_RESET, RESP, RESP_ONES, RESP_VALID,
               BUSY, dbg_state
    );

endinterface

// File: rtl/br32_sync.sv
// Multi-flop synchronizer for the ring output, which is asynchronous to clk.
module br32_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw ring output through the flop chain; clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/br32_ctrl.sv
// Challenge-response controller for the BR32 bistable ring PUF. Drives a
// challenge onto the ring, runs NUM_EVALS reset/settle/sample evaluations
// and returns a majority bit plus the count of evaluations that read 1.
module br32_ctrl
    import br32_pkg::*;
#(
    parameter int RESET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int NUM_EVALS     = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic     CLK,
    input  logic     RESET,
    br32_if.slave    bus
);

    localparam int ONES_W  = ones_width(NUM_EVALS);
    localparam int CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  ARM_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ONES_W-1:0] EVAL_LAST   = ONES_W'(NUM_EVALS - 1);
    localparam logic [ONES_W-1:0] HALF        = ONES_W'(NUM_EVALS / 2);

    // Reject parameter sets that would break the majority vote or let a
    // stale pre-reset ring value reach the sample point.
    if (NUM_EVALS < 1 || (NUM_EVALS % 2) == 0) begin : g_bad_num_evals
        $error("br32_ctrl: NUM_EVALS must be odd and >= 1");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("br32_ctrl: RESET_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("br32_ctrl: SYNC_STAGES must be >= 2");
    end
    if (SETTLE_CYCLES <= SYNC_STAGES) begin : g_bad_settle_cycles
        $error("br32_ctrl: SETTLE_CYCLES must exceed SYNC_STAGES");
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ONES_W-1:0]     evals_q, evals_d;
    logic [ONES_W-1:0]     ones_q, ones_d;
    logic [BR32_WIDTH-1:0] chal_q, chal_d;
    logic                  ready_q, ready_d;
    logic                  ring_bit;

    br32_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (bus.PUF_OUT),
        .q   (ring_bit)
    );

    // State, counters, latched challenge and the ready flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            evals_q <= '0;
            ones_q  <= '0;
            chal_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evals_q <= evals_d;
            ones_q  <= ones_d;
            chal_q  <= chal_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: phase sequencing within each evaluation and the
    // evaluation loop itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evals_d = evals_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.CHAL_VALID && ready_q) begin
                    chal_d  = bus.CHAL;
                    ones_d  = '0;
                    evals_d = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (cnt_q == ARM_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                ones_d  = ones_q + ONES_W'(ring_bit);
                evals_d = evals_q + ONES_W'(1);
                cnt_d   = '0;
                state_d = (evals_q == EVAL_LAST) ? ST_DONE : ST_ARM;
            end
            ST_DONE: begin
                if (bus.RESP_READY) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are flops or decodes of the registered state; the ring is held
    // in reset whenever no evaluation is running.
    assign bus.PUF_C      = chal_q;
    assign bus.PUF_RESET  = (state_q == ST_IDLE) || (state_q == ST_ARM) || (state_q == ST_DONE);
    assign bus.CHAL_READY = ready_q;
    assign bus.RESP_VALID = (state_q == ST_DONE);
    assign bus.RESP       = (ones_q > HALF);
    assign bus.RESP_ONES  = ones_q;
    assign bus.BUSY       = (state_q != ST_IDLE);
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_br32_ctrl.sv
// Directed bench for br32_ctrl with a behavioural BR32 ring model.
module tb_br32_ctrl;
    import br32_pkg::*;

    localparam int RC  = 2;
    localparam int SC  = 4;
    localparam int NE  = 3;
    localparam int SS  = 2;
    localparam int E   = RC + SC + 1;
    localparam int LAT = NE * E + 1;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    br32_if #(.NUM_EVALS(NE)) ifc ();

    br32_ctrl #(
        .RESET_CYCLES  (RC),
        .SETTLE_CYCLES (SC),
        .NUM_EVALS     (NE),
        .SYNC_STAGES   (SS)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifc.slave)
    );

    // Clock generation.
    always #5 CLK = ~CLK;

    // Ring model: OUT forced low while the ring is in reset; afterwards it
    // shows the scripted value for the current evaluation.
    int         falls = 0;
    int         base  = 0;
    int         ev;
    logic [7:0] scr   = '0;
    logic       model_out;

    always @(negedge ifc.PUF_RESET) falls <= falls + 1;

    always_comb begin
        model_out = 1'b0;
        ev        = falls - base - 1;
        if (!ifc.PUF_RESET && ev >= 0) model_out = scr[ev % 8];
    end

    assign ifc.PUF_OUT = model_out;

    // Checking.
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] pr_trace;
    logic [31:0] puf_c_seen;

    // Present a challenge, wait for the accept edge, then count cycles until
    // RESP_VALID while recording PUF_RESET per cycle (cycle 1 = after accept).
    task automatic run_chal(input logic [31:0] c, input logic [2:0] s, output int latency);
        int n;
        scr            = {5'b0, s};
        base           = falls;
        ifc.CHAL       = c;
        ifc.CHAL_VALID = 1'b1;
        ifc.RESP_READY = 1'b0;
        n = 0;
        while (!ifc.CHAL_READY && n < 50) begin
            tick();
            n++;
        end
        if (!ifc.CHAL_READY) begin
            check("accept_timeout", 32'd0, 32'd1);
            ifc.CHAL_VALID = 1'b0;
            latency = 0;
            return;
        end
        tick();
        ifc.CHAL_VALID = 1'b0;
        puf_c_seen  = ifc.PUF_C;
        latency     = 1;
        pr_trace    = '0;
        pr_trace[0] = ifc.PUF_RESET;
        while (!ifc.RESP_VALID && latency < 100) begin
            tick();
            latency++;
            if (latency <= 32) pr_trace[latency-1] = ifc.PUF_RESET;
        end
    endtask

    task automatic consume();
        ifc.RESP_READY = 1'b1;
        tick();
        ifc.RESP_READY = 1'b0;
    endtask

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bad;
        int          n;
        int          na;
        int          busy_low;
        int          acc[3];
        logic        rdy_pre;
        logic [31:0] exp_pr;

        ifc.CHAL       = '0;
        ifc.CHAL_VALID = 1'b0;
        ifc.RESP_READY = 1'b0;

        // Reset state while reset is held.
        repeat (3) tick();
        check("rst_puf_reset", ifc.PUF_RESET, 1);
        check("rst_puf_c", ifc.PUF_C, 0);
        check("rst_chal_ready", ifc.CHAL_READY, 0);
        check("rst_resp_valid", ifc.RESP_VALID, 0);
        check("rst_busy", ifc.BUSY, 0);
        check("rst_resp_ones", {ifc.RESP, ifc.RESP_ONES}, 0);
        check("rst_state", ifc.dbg_state, ST_IDLE);
        RESET = 1'b0;
        check("ready_at_release", ifc.CHAL_READY, 0);
        tick();
        check("ready_after_release", ifc.CHAL_READY, 1);

        // Stable 1.
        run_chal(32'hDEADBEEF, 3'b111, lat);
        check("s1_latency", lat, LAT);
        check("s1_puf_c", puf_c_seen, 32'hDEADBEEF);
        exp_pr = '0;
        for (int i = 0; i < LAT; i++) begin
            if (i + 1 <= NE * E) exp_pr[i] = (((i) % E) < RC);
            else                 exp_pr[i] = 1'b1;
        end
        check("s1_puf_reset_trace", pr_trace, exp_pr);
        check("s1_resp", ifc.RESP, 1);
        check("s1_resp_ones", ifc.RESP_ONES, 3);
        consume();
        check("s1_ready_after_consume", ifc.CHAL_READY, 1);
        check("s1_busy_after_consume", ifc.BUSY, 0);

        // Noisy runs: 1,0,0 then 0,1,1.
        run_chal(32'h00000001, 3'b001, lat);
        check("n1_latency", lat, LAT);
        check("n1_resp", ifc.RESP, 0);
        check("n1_resp_ones", ifc.RESP_ONES, 1);
        consume();
        run_chal(32'h00000001, 3'b110, lat);
        check("n2_latency", lat, LAT);
        check("n2_resp", ifc.RESP, 1);
        check("n2_resp_ones", ifc.RESP_ONES, 2);
        consume();

        // Backpressure in DONE with a new challenge waiting.
        run_chal(32'hA5A5A5A5, 3'b011, lat);
        check("bp_latency", lat, LAT);
        ifc.CHAL       = 32'h12345678;
        ifc.CHAL_VALID = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ifc.RESP !== 1'b1 || ifc.RESP_ONES !== 2 || ifc.RESP_VALID !== 1'b1 ||
                ifc.CHAL_READY !== 1'b0 || ifc.PUF_C !== 32'hA5A5A5A5) bad++;
            tick();
        end
        check("bp_hold_stable", bad, 0);
        base = falls;
        scr  = 8'b0000_0101;
        ifc.RESP_READY = 1'b1;
        tick();
        ifc.RESP_READY = 1'b0;
        check("bp_ready_next", ifc.CHAL_READY, 1);
        check("bp_not_taken_yet", ifc.PUF_C, 32'hA5A5A5A5);
        tick();
        ifc.CHAL_VALID = 1'b0;
        check("bp_accepted_chal", ifc.PUF_C, 32'h12345678);
        check("bp_ready_cleared", ifc.CHAL_READY, 0);
        n = 1;
        while (!ifc.RESP_VALID && n < 100) begin
            tick();
            n++;
        end
        check("bp2_latency", n, LAT);
        check("bp2_resp_ones", ifc.RESP_ONES, 2);
        consume();

        // Reset during SETTLE of evaluation 2.
        base           = falls;
        scr            = 8'b0000_0111;
        ifc.CHAL       = 32'hCAFEF00D;
        ifc.CHAL_VALID = 1'b1;
        tick();
        ifc.CHAL_VALID = 1'b0;
        repeat (10) tick();
        check("mr_in_settle", ifc.dbg_state, ST_SETTLE);
        check("mr_ring_free", ifc.PUF_RESET, 0);
        #2;
        RESET = 1'b1;
        #1;
        check("mr_puf_reset", ifc.PUF_RESET, 1);
        check("mr_puf_c", ifc.PUF_C, 0);
        check("mr_chal_ready", ifc.CHAL_READY, 0);
        check("mr_resp_valid", ifc.RESP_VALID, 0);
        check("mr_busy", ifc.BUSY, 0);
        check("mr_resp_ones", {ifc.RESP, ifc.RESP_ONES}, 0);
        tick();
        RESET = 1'b0;
        tick();
        check("mr_ready_after_release", ifc.CHAL_READY, 1);
        run_chal(32'h0F0F0F0F, 3'b101, lat);
        check("mr_latency", lat, LAT);
        check("mr_resp", ifc.RESP, 1);
        check("mr_resp_ones", ifc.RESP_ONES, 2);
        consume();

        // Back-to-back with both handshakes tied high.
        base           = falls;
        scr            = 8'hFF;
        ifc.CHAL       = 32'h55AA55AA;
        ifc.CHAL_VALID = 1'b1;
        ifc.RESP_READY = 1'b1;
        na       = 0;
        busy_low = 0;
        acc      = '{default: 0};
        for (int i = 0; i < 80 && na < 3; i++) begin
            rdy_pre = ifc.CHAL_READY;
            tick();
            if (rdy_pre) begin
                acc[na] = i;
                na++;
            end else if (na == 1 && !ifc.BUSY) begin
                busy_low++;
            end
        end
        ifc.CHAL_VALID = 1'b0;
        check("b2b_accept_count", na, 3);
        check("b2b_gap1", acc[1] - acc[0], E * NE + 2);
        check("b2b_gap2", acc[2] - acc[1], E * NE + 2);
        check("b2b_busy_low", busy_low, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
